conv_encoder_param: RTL

Parametrised, runtime-configurable rate-1/N convolutional encoder with radix-2^R input, one beat per cycle under a valid/ready handshake. Encode mode streams a frame with automatic zero-tail flushing. Table mode sweeps every (state, input) pair and emits the full trellis table (current state, input, next state, code bits) for the decoder's branch-metric and trellis memories.

---
 rtl/conv_enc_pkg.sv | 39 +++
 rtl/conv_encoder_param_if.sv | 52 +++++
 rtl/conv_enc_step.sv | 32 +++
 rtl/conv_encoder_param.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_enc_pkg.sv
// Shared types and helpers for the parametrised convolutional encoder.
// Holds the FSM state enum plus the mask, clamp and tail-length helpers.
package conv_enc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StEnc,
        StFlush,
        StTab
    } enc_state_e;

    // Low `width` bits set; used to confine registers to the active constraint length.
    function automatic logic [31:0] k_mask(input int unsigned width);
        if (width >= 32) begin
            return '1;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

    function automatic logic [3:0] clamp_k(input logic [3:0] k, input int unsigned k_max);
        int unsigned kv;
        kv = 32'(k);
        if (kv < 3) begin
            return 4'd3;
        end
        if (kv > k_max) begin
            return 4'(k_max);
        end
        return k;
    endfunction

    // Number of zero beats needed to shift k-1 history bits out, R bits per beat.
    function automatic logic [3:0] tail_beats(input logic [3:0] k, input int unsigned r);
        int unsigned kv;
        kv = 32'(k);
        return 4'((kv - 1 + r - 1) / r);
    endfunction

endpackage

// File: rtl/conv_encoder_param_if.sv
// Input beat and output beat handshake bundle of the convolutional encoder.
// The encoder uses the slave view; the producer/consumer side uses master.
interface conv_encoder_param_if #(
    parameter int unsigned K_MAX = 9,
    parameter int unsigned N_OUT = 2,
    parameter int unsigned R     = 2
) ();

    localparam int unsigned S = K_MAX - 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [R-1:0]         in_bits;
    logic                 in_last;

    logic                 out_valid;
    logic                 out_ready;
    logic [R*N_OUT-1:0]   out_bits;
    logic [R-1:0]         out_in;
    logic [S-1:0]         out_state;
    logic [S-1:0]         out_next;
    logic                 out_last;

    modport slave (
        input  in_valid,
        input  in_bits,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_bits,
        output out_in,
        output out_state,
        output out_next,
        output out_last
    );

    modport master (
        output in_valid,
        output in_bits,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_bits,
        input  out_in,
        input  out_state,
        input  out_next,
        input  out_last
    );

endinterface

// File: rtl/conv_enc_step.sv
// One trellis step: shifts input bit b into state s and produces N_OUT code bits.
// Purely combinational; the top chains R of these per beat.
module conv_enc_step
    import conv_enc_pkg::*;
#(
    parameter int unsigned K_MAX = 9,
    parameter int unsigned N_OUT = 2
) (
    input  logic [K_MAX-2:0]       s,
    input  logic                   b,
    input  logic [N_OUT*K_MAX-1:0] polys,
    input  logic [3:0]             k,
    output logic [N_OUT-1:0]       c,
    output logic [K_MAX-2:0]       next_state
);

    localparam int unsigned S = K_MAX - 1;

    logic [K_MAX-1:0] u;

    always_comb begin
        u = '0;
        c = '0;
        // Masking u also drops polynomial taps at or above k.
        u = {s, b} & K_MAX'(k_mask(32'(k)));
        for (int j = 0; j < N_OUT; j++) begin
            c[j] = ^(polys[j*K_MAX +: K_MAX] & u);
        end
        next_state = u[S-1:0] & S'(k_mask(32'(k) - 32'd1));
    end

endmodule

// File: rtl/conv_encoder_param.sv
// Runtime-configurable rate-1/N, radix-2^R convolutional encoder.
// Encode mode streams a frame and appends a zero tail; table mode emits the full trellis.
module conv_encoder_param
    import conv_enc_pkg::*;
#(
    parameter int unsigned K_MAX = 9,
    parameter int unsigned N_OUT = 2,
    parameter int unsigned R     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   mode,
    input  logic [3:0]             cfg_k,
    input  logic [N_OUT*K_MAX-1:0] cfg_poly,
    output logic                   busy,
    conv_encoder_param_if.slave    bus
);

    localparam int unsigned S  = K_MAX - 1;
    localparam int unsigned IW = S + R;

    enc_state_e               st_q, st_d;
    logic [3:0]               k_q, k_d;
    logic [N_OUT*K_MAX-1:0]   poly_q, poly_d;
    logic [S-1:0]             enc_q, enc_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [3:0]               tail_q, tail_d;

    logic                     out_valid_q, out_valid_d;
    logic [R*N_OUT-1:0]       out_bits_q, out_bits_d;
    logic [R-1:0]             out_in_q, out_in_d;
    logic [S-1:0]             out_state_q, out_state_d;
    logic [S-1:0]             out_next_q, out_next_d;
    logic                     out_last_q, out_last_d;

    logic [S-1:0]             step_s0;
    logic [R-1:0]             step_b;
    logic [R-1:0][S-1:0]      step_ns;
    logic [R-1:0][N_OUT-1:0]  step_c;
    logic [R*N_OUT-1:0]       code_bits;
    logic [IW-1:0]            idx_last;

    logic                     load_ok;
    logic                     load;
    logic                     load_last;

    // Sub-step r lands at code_bits[r*N_OUT +: N_OUT] by packed-array layout.
    assign code_bits = step_c;
    assign idx_last  = IW'(k_mask(32'(k_q) - 32'd1 + R));
    assign load_ok   = !out_valid_q || bus.out_ready;
    assign busy      = (st_q != StIdle);

    for (genvar r = 0; r < R; r++) begin : g_step
        logic [S-1:0] s_in;
        if (r == 0) begin : g_first
            assign s_in = step_s0;
        end else begin : g_chain
            assign s_in = step_ns[r-1];
        end
        conv_enc_step #(
            .K_MAX (K_MAX),
            .N_OUT (N_OUT)
        ) u_step (
            .s          (s_in),
            .b          (step_b[r]),
            .polys      (poly_q),
            .k          (k_q),
            .c          (step_c[r]),
            .next_state (step_ns[r])
        );
    end

    // Step-chain source: live encoder state, or the {state, input} split of the table index.
    always_comb begin
        step_s0 = enc_q;
        step_b  = '0;
        unique case (st_q)
            StEnc: begin
                step_b = bus.in_bits;
            end
            StTab: begin
                step_s0 = idx_q[IW-1:R];
                step_b  = idx_q[R-1:0];
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        st_d         = st_q;
        k_d          = k_q;
        poly_d       = poly_q;
        enc_d        = enc_q;
        idx_d        = idx_q;
        tail_d       = tail_q;
        load         = 1'b0;
        load_last    = 1'b0;
        bus.in_ready = 1'b0;

        unique case (st_q)
            StIdle: begin
                if (start) begin
                    k_d    = clamp_k(cfg_k, K_MAX);
                    poly_d = cfg_poly;
                    if (mode) begin
                        idx_d = '0;
                        st_d  = StTab;
                    end else begin
                        enc_d = '0;
                        st_d  = StEnc;
                    end
                end
            end
            StEnc: begin
                bus.in_ready = load_ok;
                if (bus.in_valid && load_ok) begin
                    load  = 1'b1;
                    enc_d = step_ns[R-1];
                    if (bus.in_last) begin
                        st_d   = StFlush;
                        tail_d = tail_beats(k_q, R);
                    end
                end
            end
            StFlush: begin
                if (load_ok) begin
                    load      = 1'b1;
                    load_last = (tail_q == 4'd1);
                    enc_d     = step_ns[R-1];
                    tail_d    = tail_q - 4'd1;
                    if (load_last) begin
                        st_d = StIdle;
                    end
                end
            end
            StTab: begin
                if (load_ok) begin
                    load      = 1'b1;
                    load_last = (idx_q == idx_last);
                    idx_d     = idx_q + IW'(1);
                    if (load_last) begin
                        idx_d = '0;
                        st_d  = StIdle;
                    end
                end
            end
            default: begin
                st_d = StIdle;
            end
        endcase
    end

    // Output register: drains when accepted, reloads whenever the FSM issues a beat.
    always_comb begin
        out_valid_d = out_valid_q;
        out_bits_d  = out_bits_q;
        out_in_d    = out_in_q;
        out_state_d = out_state_q;
        out_next_d  = out_next_q;
        out_last_d  = out_last_q;
        if (load_ok) begin
            out_valid_d = load;
        end
        if (load) begin
            out_bits_d  = code_bits;
            out_in_d    = step_b;
            out_state_d = step_s0;
            out_next_d  = step_ns[R-1];
            out_last_d  = load_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= StIdle;
            k_q         <= '0;
            poly_q      <= '0;
            enc_q       <= '0;
            idx_q       <= '0;
            tail_q      <= '0;
            out_valid_q <= 1'b0;
            out_bits_q  <= '0;
            out_in_q    <= '0;
            out_state_q <= '0;
            out_next_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            st_q        <= st_d;
            k_q         <= k_d;
            poly_q      <= poly_d;
            enc_q       <= enc_d;
            idx_q       <= idx_d;
            tail_q      <= tail_d;
            out_valid_q <= out_valid_d;
            out_bits_q  <= out_bits_d;
            out_in_q    <= out_in_d;
            out_state_q <= out_state_d;
            out_next_q  <= out_next_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_bits  = out_bits_q;
    assign bus.out_in    = out_in_q;
    assign bus.out_state = out_state_q;
    assign bus.out_next  = out_next_q;
    assign bus.out_last  = out_last_q;

endmodule
